// File: rtl/axis_pipe_pkg.sv
// Shared types and helpers for the AXI4-Stream pipeline slice.
// Stage-state encoding, stage-count limit and occupancy width computation.
package axis_pipe_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } stage_state_e;

  localparam int unsigned MAX_STAGES = 16;

  // Bits needed to count 0..2*stages held beats.
  function automatic int unsigned occ_width(input int unsigned stages);
    return unsigned'($clog2(2 * stages + 1));
  endfunction

endpackage

// File: rtl/axis_skid_stage.sv
// One full-throughput skid stage: main + skid register with registered ready.
// Payload is {tlast, tdata}; out_data_o is the main register.
module axis_skid_stage
  import axis_pipe_pkg::*;
#(
  parameter int unsigned PAYLOAD_W = 9
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [PAYLOAD_W-1:0] in_data_i,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  output logic [PAYLOAD_W-1:0] out_data_o,
  output logic                 out_valid_o,
  input  logic                 out_ready_i
);

  stage_state_e         state_q, state_d;
  logic [PAYLOAD_W-1:0] main_q, main_d;
  logic [PAYLOAD_W-1:0] skid_q, skid_d;
  logic                 ready_q, ready_d;
  logic                 valid_q, valid_d;
  logic                 in_fire;
  logic                 out_fire;

  assign in_fire  = in_valid_i && ready_q;
  assign out_fire = valid_q && out_ready_i;

  assign in_ready_o  = ready_q;
  assign out_valid_o = valid_q;
  assign out_data_o  = main_q;

  // Ready stays low out of reset until the first edge with reset released.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
      ready_q <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
      ready_q <= ready_d;
      valid_q <= valid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      ST_EMPTY: begin
        if (in_fire) begin
          state_d = ST_ONE;
          main_d  = in_data_i;
        end
      end
      ST_ONE: begin
        if (in_fire && !out_fire) begin
          state_d = ST_FULL;
          skid_d  = in_data_i;
        end else if (!in_fire && out_fire) begin
          state_d = ST_EMPTY;
        end else if (in_fire && out_fire) begin
          main_d = in_data_i;
        end
      end
      ST_FULL: begin
        // Input is never accepted here because ready_q is low.
        if (out_fire) begin
          state_d = ST_ONE;
          main_d  = skid_q;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    ready_d = (state_d != ST_FULL);
    valid_d = (state_d != ST_EMPTY);
  end

endmodule

// File: rtl/axis_pipe_slice.sv
// AXI4-Stream register pipeline of STAGES cascaded skid stages with occupancy.
// Optional AXIS_PIPE_STATS_EN adds beat_count / pkt_count output counters.
module axis_pipe_slice
  import axis_pipe_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned STAGES     = 2,
  parameter int unsigned OCC_WIDTH  = occ_width(STAGES)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  input  logic                  s_axis_tlast,
  output logic                  s_axis_tready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  output logic                  m_axis_tlast,
  input  logic                  m_axis_tready,
  output logic [OCC_WIDTH-1:0]  occupancy
`ifdef AXIS_PIPE_STATS_EN
 ,output logic [31:0]           beat_count,
  output logic [15:0]           pkt_count
`endif
);

  localparam int unsigned PAYLOAD_W = DATA_WIDTH + 1;

  logic [STAGES:0][PAYLOAD_W-1:0] link_data;
  logic [STAGES:0]                link_valid;
  logic [STAGES:0]                link_ready;
  logic                           s_fire;
  logic                           m_fire;
  logic [OCC_WIDTH-1:0]           occ_q, occ_d;

  assign link_data[0]       = {s_axis_tlast, s_axis_tdata};
  assign link_valid[0]      = s_axis_tvalid;
  assign s_axis_tready      = link_ready[0];
  assign link_ready[STAGES] = m_axis_tready;

  for (genvar i = 0; i < STAGES; i++) begin : g_stage
    axis_skid_stage #(
      .PAYLOAD_W(PAYLOAD_W)
    ) u_stage (
      .clk        (clk),
      .reset      (reset),
      .in_data_i  (link_data[i]),
      .in_valid_i (link_valid[i]),
      .in_ready_o (link_ready[i]),
      .out_data_o (link_data[i+1]),
      .out_valid_o(link_valid[i+1]),
      .out_ready_i(link_ready[i+1])
    );
  end

  assign m_axis_tdata  = link_data[STAGES][DATA_WIDTH-1:0];
  assign m_axis_tlast  = link_data[STAGES][DATA_WIDTH];
  assign m_axis_tvalid = link_valid[STAGES];

  assign s_fire = s_axis_tvalid && s_axis_tready;
  assign m_fire = m_axis_tvalid && m_axis_tready;

  // Occupancy tracks beats held across all stages; bounded by the stage FSMs.
  always_comb begin
    occ_d = occ_q;
    case ({s_fire, m_fire})
      2'b10:   occ_d = occ_q + OCC_WIDTH'(1);
      2'b01:   occ_d = occ_q - OCC_WIDTH'(1);
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      occ_q <= '0;
    end else begin
      occ_q <= occ_d;
    end
  end

  assign occupancy = occ_q;

`ifdef AXIS_PIPE_STATS_EN
  logic [31:0] beat_q, beat_d;
  logic [15:0] pkt_q, pkt_d;

  // Free-running wrap-around counters of downstream beats and packets.
  always_comb begin
    beat_d = beat_q;
    pkt_d  = pkt_q;
    if (m_fire) begin
      beat_d = beat_q + 32'd1;
      if (m_axis_tlast) begin
        pkt_d = pkt_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      beat_q <= '0;
      pkt_q  <= '0;
    end else begin
      beat_q <= beat_d;
      pkt_q  <= pkt_d;
    end
  end

  assign beat_count = beat_q;
  assign pkt_count  = pkt_q;
`endif

endmodule

// File: tb/tb_axis_pipe_slice.sv
// Bench for axis_pipe_slice: queue-based stream model plus directed scenarios.
// Stats counters are checked when AXIS_PIPE_STATS_EN is defined.
module tb_axis_pipe_slice;

  localparam int unsigned DW     = 8;
  localparam int unsigned STAGES = 2;
  localparam int unsigned OCC_W  = $clog2(2 * STAGES + 1);
  localparam int unsigned CAP    = 2 * STAGES;

  logic             clk;
  logic             reset;
  logic [DW-1:0]    s_tdata;
  logic             s_tvalid;
  logic             s_tlast;
  logic             s_tready;
  logic [DW-1:0]    m_tdata;
  logic             m_tvalid;
  logic             m_tlast;
  logic             m_tready;
  logic [OCC_W-1:0] occupancy;
`ifdef AXIS_PIPE_STATS_EN
  logic [31:0]      beat_count;
  logic [15:0]      pkt_count;
`endif

  int errors = 0;
  int checks = 0;

  logic [DW:0] model_q[$];
  logic [DW:0] out_log[$];
  logic        hold_prev = 1'b0;
  logic [DW:0] held = '0;

  axis_pipe_slice #(
    .DATA_WIDTH(DW),
    .STAGES    (STAGES)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .s_axis_tdata (s_tdata),
    .s_axis_tvalid(s_tvalid),
    .s_axis_tlast (s_tlast),
    .s_axis_tready(s_tready),
    .m_axis_tdata (m_tdata),
    .m_axis_tvalid(m_tvalid),
    .m_axis_tlast (m_tlast),
    .m_axis_tready(m_tready),
    .occupancy    (occupancy)
`ifdef AXIS_PIPE_STATS_EN
   ,.beat_count   (beat_count),
    .pkt_count    (pkt_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input longint got, input longint exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_empty(input string name, input bit rand_ready);
    int g = 0;
    s_tvalid = 1'b0;
    while (occupancy != 0 && g < 400) begin
      m_tready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      tick();
      g++;
    end
    check(name, longint'(occupancy), 0);
  endtask

  // Model: accepted-but-not-emitted beats in FIFO order, checked every cycle.
  always @(negedge clk) begin
    check("occupancy_vs_model", longint'(occupancy), longint'(model_q.size()));
    if (m_tvalid) begin
      if (model_q.size() == 0) check("unexpected_out_beat", 1, 0);
      else check("out_beat", longint'({m_tlast, m_tdata}), longint'(model_q[0]));
    end
    if (hold_prev)
      check("hold_stable", longint'({m_tvalid, m_tlast, m_tdata}), longint'({1'b1, held}));
    if (model_q.size() >= CAP)
      check("ready_low_when_full", longint'(s_tready), 0);
    if (!reset) begin
      model_q.delete();
      hold_prev = 1'b0;
    end else begin
      if (m_tvalid && m_tready) begin
        out_log.push_back({m_tlast, m_tdata});
        if (model_q.size() != 0) void'(model_q.pop_front());
      end
      if (s_tvalid && s_tready) model_q.push_back({s_tlast, s_tdata});
      hold_prev = m_tvalid && !m_tready;
      held      = {m_tlast, m_tdata};
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int nxt;
    int g;
    int sent;
    int tl_sent;
    int tl_seen;
    logic acc;

    reset    = 1'b0;
    s_tvalid = 1'b0;
    s_tdata  = '0;
    s_tlast  = 1'b0;
    m_tready = 1'b0;

    // Reset for three cycles, then ready rises one edge after release.
    repeat (3) tick();
    check("rst_tready", longint'(s_tready), 0);
    check("rst_tvalid", longint'(m_tvalid), 0);
    check("rst_tdata", longint'(m_tdata), 0);
    check("rst_tlast", longint'(m_tlast), 0);
    check("rst_occ", longint'(occupancy), 0);
    reset = 1'b1;
    tick();
    check("tready_after_rst", longint'(s_tready), 1);

    // Stream 1..10 with both sides ready.
    out_log.delete();
    m_tready = 1'b1;
    lat = -1;
    for (int i = 1; i <= 10; i++) begin
      s_tvalid = 1'b1;
      s_tdata  = DW'(i);
      s_tlast  = 1'b0;
      tick();
      if (lat < 0 && m_tvalid) lat = i;
      if (s_tready != 1'b1) check("stream_tready", longint'(s_tready), 1);
    end
    check("first_latency", longint'(lat), longint'(STAGES));
    check("stream_occ", longint'(occupancy), longint'(STAGES));
    wait_empty("stream_drain", 1'b0);
    check("stream_count", longint'(out_log.size()), 10);
    for (int i = 0; i < 10 && i < out_log.size(); i++)
      check("stream_order", longint'(out_log[i]), longint'(i + 1));

    // Full backpressure: present six beats with downstream stalled.
    out_log.delete();
    m_tready = 1'b0;
    nxt = 1;
    for (int c = 0; c < 12 && nxt <= 6; c++) begin
      s_tvalid = 1'b1;
      s_tdata  = DW'(nxt);
      s_tlast  = 1'b0;
      acc = s_tready;
      tick();
      if (acc) nxt++;
    end
    check("bp_accepted", longint'(nxt - 1), longint'(CAP));
    check("bp_tready", longint'(s_tready), 0);
    check("bp_occ", longint'(occupancy), longint'(CAP));
    wait_empty("bp_drain", 1'b0);
    check("bp_count", longint'(out_log.size()), longint'(CAP));
    for (int i = 0; i < out_log.size(); i++)
      check("bp_order", longint'(out_log[i]), longint'(i + 1));

    // Packet of 11 beats, tlast only on 0x3F, random downstream ready.
    out_log.delete();
    for (int k = 0; k < 11; k++) begin
      s_tvalid = 1'b1;
      s_tdata  = (k == 10) ? DW'(8'h3F) : DW'(8'h20 + k);
      s_tlast  = (k == 10);
      g = 0;
      do begin
        m_tready = 1'($urandom_range(0, 1));
        acc = s_tready;
        tick();
        g++;
      end while (!acc && g < 200);
      if (!acc) check("pkt_accept_timeout", 0, 1);
    end
    wait_empty("pkt_drain", 1'b1);
    check("pkt_count", longint'(out_log.size()), 11);
    for (int k = 0; k < 11 && k < out_log.size(); k++)
      check("pkt_beat", longint'(out_log[k]),
            (k == 10) ? longint'(9'h13F) : longint'(8'h20 + k));

    // Reset while full: held beats are discarded.
    out_log.delete();
    m_tready = 1'b0;
    nxt = 0;
    for (int c = 0; c < 20 && nxt < CAP; c++) begin
      s_tvalid = 1'b1;
      s_tdata  = DW'(8'hA1 + nxt);
      s_tlast  = 1'b0;
      acc = s_tready;
      tick();
      if (acc) nxt++;
    end
    s_tvalid = 1'b0;
    tick();
    check("mid_full_occ", longint'(occupancy), longint'(CAP));
    reset = 1'b0;
    tick();
    check("mid_rst_tvalid", longint'(m_tvalid), 0);
    check("mid_rst_occ", longint'(occupancy), 0);
    check("mid_rst_tready", longint'(s_tready), 0);
    reset = 1'b1;
    tick();
    check("mid_rst_tready_rise", longint'(s_tready), 1);
    m_tready = 1'b1;
    repeat (6) tick();
    check("mid_rst_no_old_beats", longint'(out_log.size()), 0);
    check("mid_rst_idle_valid", longint'(m_tvalid), 0);

    // Random traffic: 2048 beats with random valid, ready and tlast.
    out_log.delete();
    sent = 0;
    tl_sent = 0;
    g = 0;
    while (sent < 2048 && g < 40000) begin
      s_tvalid = 1'($urandom_range(0, 1));
      s_tdata  = DW'($urandom);
      s_tlast  = ($urandom_range(0, 7) == 0);
      m_tready = 1'($urandom_range(0, 1));
      acc = s_tvalid && s_tready;
      tick();
      g++;
      if (acc) begin
        sent++;
        if (s_tlast) tl_sent++;
      end
    end
    check("rand_sent", longint'(sent), 2048);
    wait_empty("rand_drain", 1'b0);
    check("rand_out_count", longint'(out_log.size()), 2048);
    tl_seen = 0;
    foreach (out_log[i]) if (out_log[i][DW]) tl_seen++;
    check("rand_tlast_count", longint'(tl_seen), longint'(tl_sent));
`ifdef AXIS_PIPE_STATS_EN
    check("stats_beat_count", longint'(beat_count), 2048);
    check("stats_pkt_count", longint'(pkt_count), longint'(tl_sent % 65536));
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/axis_pipe_slice.md
Name: axis_pipe_slice

Overview:
- Parametrised AXI4-Stream register pipeline, the next generation of the single-stage stream `register`.
- Inserts STAGES full-throughput skid-buffer stages between an upstream master and a downstream slave to break timing paths on tdata, tvalid, tlast and tready.
- Sits between the fixed-point datapath blocks (Q2.6 samples by default) and carries packet framing on tlast.
- Sustains 1 beat/cycle with registered tready on every stage; no beat is ever lost or duplicated.

Parameters:
- DATA_WIDTH, 8, tdata width in bits (>=1).
- STAGES, 2, number of cascaded skid stages (1..16).
- OCC_WIDTH, $clog2(2*STAGES+1), width of the occupancy output (derived; do not override).

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-low reset (reset==0 resets on the clk edge).
- s_axis_tdata  in  DATA_WIDTH  upstream data.
- s_axis_tvalid  in  1  upstream valid.
- s_axis_tlast  in  1  upstream end-of-packet.
- s_axis_tready  out  1  ready to upstream; registered.
- m_axis_tdata  out  DATA_WIDTH  downstream data; registered.
- m_axis_tvalid  out  1  downstream valid; registered.
- m_axis_tlast  out  1  downstream end-of-packet; registered.
- m_axis_tready  in  1  downstream ready.
- occupancy  out  OCC_WIDTH  number of beats currently held, 0..2*STAGES.

Behaviour:
- Handshakes:
  - A transfer occurs when tvalid && tready on a clk edge.
  - tdata and tlast travel together as one beat.
  - Once m_axis_tvalid=1, m_axis_tdata, m_axis_tlast and m_axis_tvalid hold stable until the beat is accepted.
- Reset (reset==0 at a clk edge):
  - m_axis_tvalid=0, m_axis_tdata=0, m_axis_tlast=0, s_axis_tready=0, occupancy=0, every stage EMPTY.
  - s_axis_tready rises on the first edge after reset returns to 1.
  - Reset during a transfer discards all held beats; no partial-packet flush is performed.
- Each stage holds a main register and a skid register, and runs a 3-state FSM: EMPTY, ONE (main valid), FULL (main+skid valid).
  - EMPTY: in accepted -> ONE.
  - ONE: in accepted and out not accepted -> FULL. Out accepted and no in -> EMPTY. Both accepted -> ONE, main replaced.
  - FULL: out accepted -> ONE, skid moved to main. No input is accepted in FULL.
  - Stage in_ready = registered (state != FULL). Stage out_valid = (state != EMPTY).
- Latency and throughput:
  - First beat into an empty pipe appears on m_axis after STAGES cycles.
  - Steady state with both sides always ready: 1 beat/cycle, s_axis_tready stays 1.
- Backpressure: m_axis_tready=0 indefinitely fills all 2*STAGES entries; s_axis_tready then falls and stays 0.
- Occupancy:
  - Increments on an input transfer and decrements on an output transfer, registered.
  - Simultaneous input and output transfers leave it unchanged.
  - Never exceeds 2*STAGES or wraps below 0.
- Ordering: strict FIFO; tlast stays attached to its own beat.
- Inputs sampled while s_axis_tready=0 are ignored, even if s_axis_tvalid=1.

Optional Feature:
- Macro AXIS_PIPE_STATS_EN.
- When defined, adds outputs beat_count[31:0] and pkt_count[15:0]:
  - beat_count counts m_axis transfers.
  - pkt_count counts m_axis transfers with tlast=1.
  - Both wrap modulo 2^N, clear on reset, and update on the same edge as the transfer.
- When undefined, neither port nor its logic exists, and the behaviour above is unchanged.

Decomposition:
- Package axis_pipe_pkg:
  - stage-state enum (ST_EMPTY=2'd0, ST_ONE=2'd1, ST_FULL=2'd2);
  - MAX_STAGES=16;
  - a function computing OCC_WIDTH.
- Sub-module axis_skid_stage (one stage, DATA_WIDTH+1 payload carrying tlast). The top instantiates it STAGES times in a generate loop and keeps the occupancy and stats counters.

Test Plan:
- Reset then stream: reset=0 for 3 cycles, then stream 0x01..0x0A with both sides ready -> m_axis emits 0x01..0x0A in order with first m_axis_tvalid STAGES cycles after first accept; s_axis_tready stays 1; occupancy settles at STAGES.
- Full backpressure: STAGES=2, m_axis_tready=0, drive 6 beats -> exactly 4 accepted, s_axis_tready=0 after the 4th, occupancy=4; release ready -> 0x01..0x04 emitted and no beat lost.
- Packet framing: tlast on beat 11 of 11 (0x3F at index 10) with random m_axis_tready at 50% -> m_axis_tlast=1 only with 0x3F; output order identical to input.
- Reset mid-operation: pipe full at occupancy=4, assert reset for 1 cycle -> next edge m_axis_tvalid=0, occupancy=0, s_axis_tready=0, then 1 a cycle later; old beats never reappear.
- Parameter sweep: DATA_WIDTH=16, STAGES=1 and STAGES=8, random valid/ready for 2048 beats -> scoreboard matches every beat; occupancy never exceeds 2*STAGES; with AXIS_PIPE_STATS_EN, beat_count=2048 and pkt_count equals the number of tlast beats sent.
